spi_phase_sequencer: RTL

Parametrised successor to the SPI setup decoder: accepts one flash-transaction request and emits, one per handshake, an ordered stream of phase descriptors (command, address, alternate/mode, dummy, tx-data, rx-data). Each descriptor carries its lane width, DTR flag, bit count, SCLK cycle count and left-aligned payload. The block sits between the CSR/XIP front-end and the SPI shift engine. It adds per-phase lane selection, DTR, alternate bytes, generic address/data widths, back-pressure and abort over the fixed 8-case decoder.

---
 rtl/spi_seq_pkg.sv | 46 ++++
 rtl/spi_byte_swap.sv | 22 ++
 rtl/spi_phase_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI phase sequencer: phase codes, lane
// encodings, FSM states and the cycle-count / phase-ordering functions.
package spi_seq_pkg;

  localparam logic [2:0] PH_CMD   = 3'd0;
  localparam logic [2:0] PH_ADDR  = 3'd1;
  localparam logic [2:0] PH_ALT   = 3'd2;
  localparam logic [2:0] PH_DUMMY = 3'd3;
  localparam logic [2:0] PH_TX    = 3'd4;
  localparam logic [2:0] PH_RX    = 3'd5;

  localparam logic [1:0] LANES_SINGLE = 2'b00;
  localparam logic [1:0] LANES_DUAL   = 2'b01;
  localparam logic [1:0] LANES_QUAD   = 2'b10;

  localparam int CNT_W = 16;

  // Phase states are contiguous so that state = phase index + 1.
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_ALT, S_DUMMY, S_TX, S_RX, S_FIN
  } state_t;

  function automatic logic [CNT_W-1:0] ceil_div_lanes(input logic [CNT_W-1:0] nbits,
                                                      input logic [1:0]       lanes,
                                                      input logic             dtr);
    logic [CNT_W:0] c;
    case (lanes)
      LANES_DUAL: c = ({1'b0, nbits} + (CNT_W+1)'(1)) >> 1;
      LANES_QUAD: c = ({1'b0, nbits} + (CNT_W+1)'(3)) >> 2;
      default:    c = {1'b0, nbits};
    endcase
    if (dtr) c = (c + (CNT_W+1)'(1)) >> 1;
    return c[CNT_W-1:0];
  endfunction

  // First enabled phase strictly after cur; en[i] enables state i+1.
  function automatic state_t next_phase(input state_t cur, input logic [5:0] en);
    state_t nxt;
    nxt = S_FIN;
    for (int i = 5; i >= 0; i--) begin
      if (en[i] && ((i + 1) > int'(cur))) nxt = state_t'(3'(i + 1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/spi_byte_swap.sv
// Optional byte reversal of a DATA_W-wide word (byte 0 <-> byte N-1, ...).
module spi_byte_swap
  import spi_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] din,
  input  logic              swap_en,
  output logic [DATA_W-1:0] dout
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] rev;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign rev[8*i +: 8] = din[8*(NB-1-i) +: 8];
  end

  assign dout = swap_en ? rev : din;

endmodule

// File: rtl/spi_phase_sequencer.sv
// Turns one captured flash-transaction request into an ordered stream of
// phase descriptors (cmd, addr, alt, dummy, tx, rx) for the SPI shift engine.
module spi_phase_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NBITS_W = 8,
  parameter int DUMMY_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  cmd_en,
  input  logic                  addr_en,
  input  logic                  alt_en,
  input  logic                  tx_en,
  input  logic                  rx_en,
  input  logic [7:0]            command,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  fourbyteaddr_on,
  input  logic [7:0]            alt,
  input  logic [DUMMY_W-1:0]    dummy_cycles,
  input  logic [NBITS_W-1:0]    ntxbits,
  input  logic [DATA_W-1:0]     datain,
  input  logic [NBITS_W-1:0]    nrxbits,
  input  logic                  swap_en,
  input  logic [1:0]            lanes_cmd,
  input  logic [1:0]            lanes_addr,
  input  logic [1:0]            lanes_alt,
  input  logic [1:0]            lanes_data,
  input  logic                  dtr_en,
  input  logic                  abort,
  output logic                  ph_valid,
  input  logic                  ph_ready,
  output logic [2:0]            ph_type,
  output logic [1:0]            ph_lanes,
  output logic                  ph_dtr,
  output logic [NBITS_W-1:0]    ph_nbits,
  output logic [NBITS_W-1:0]    ph_cycles,
  output logic [((DATA_W > ADDR_W) ? DATA_W : ADDR_W)-1:0] ph_data,
  output logic                  ph_last,
  output logic                  done,
  output logic [NBITS_W+3:0]    total_edges
);

  localparam int PD_W      = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int AX_W      = (ADDR_W > 32) ? ADDR_W : 32;
  localparam int ADDR32_SH = (PD_W >= 32) ? PD_W - 32 : 0;
  localparam int SUM_W     = NBITS_W + 3;
  localparam int REQ_W     = 5 + 8 + ADDR_W + 1 + 8 + DUMMY_W + NBITS_W + DATA_W
                             + NBITS_W + 8 + 1;

  state_t               state_q, state_d;
  logic [REQ_W-1:0]     req_q, req_d, req_live;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic                 ph_valid_q, ph_valid_d;
  logic [2:0]           ph_type_q, ph_type_d;
  logic [1:0]           ph_lanes_q, ph_lanes_d;
  logic                 ph_dtr_q, ph_dtr_d;
  logic [NBITS_W-1:0]   ph_nbits_q, ph_nbits_d;
  logic [NBITS_W-1:0]   ph_cycles_q, ph_cycles_d;
  logic [PD_W-1:0]      ph_data_q, ph_data_d;
  logic                 ph_last_q, ph_last_d;

  logic                 accept;
  logic [DATA_W-1:0]    datain_sw;
  logic [5:0]           en_r;
  logic [NBITS_W-1:0]   tx_nbits;
  logic [AX_W-1:0]      addr_ext;
  logic                 is_dummy;

  logic                 r_cmd_en, r_addr_en, r_alt_en, r_tx_en, r_rx_en;
  logic [7:0]           r_command, r_alt;
  logic [ADDR_W-1:0]    r_address;
  logic                 r_four, r_dtr;
  logic [DUMMY_W-1:0]   r_dummy;
  logic [NBITS_W-1:0]   r_ntx, r_nrx;
  logic [DATA_W-1:0]    r_datain;
  logic [1:0]           r_lanes_cmd, r_lanes_addr, r_lanes_alt, r_lanes_data;

  spi_byte_swap #(.DATA_W(DATA_W)) u_swap (
    .din     (datain),
    .swap_en (swap_en),
    .dout    (datain_sw)
  );

  assign accept   = req_valid && (state_q == S_IDLE) && !abort;
  assign req_live = {cmd_en, addr_en, alt_en, tx_en, rx_en, command, address,
                     fourbyteaddr_on, alt, dummy_cycles, ntxbits, datain_sw, nrxbits,
                     lanes_cmd, lanes_addr, lanes_alt, lanes_data, dtr_en};

  // On the accept cycle the live inputs feed the first descriptor directly,
  // afterwards only the captured copy is used.
  always_comb begin
    req_d = accept ? req_live : req_q;
  end

  assign {r_cmd_en, r_addr_en, r_alt_en, r_tx_en, r_rx_en, r_command, r_address,
          r_four, r_alt, r_dummy, r_ntx, r_datain, r_nrx,
          r_lanes_cmd, r_lanes_addr, r_lanes_alt, r_lanes_data, r_dtr} = req_d;

  assign en_r = {r_rx_en && (r_nrx != '0), r_tx_en && (r_ntx != '0), r_dummy != '0,
                 r_alt_en, r_addr_en, r_cmd_en};

  assign tx_nbits = (int'(r_ntx) > DATA_W) ? NBITS_W'(DATA_W) : r_ntx;
  assign addr_ext = AX_W'(r_address);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    if (accept) begin
      sum_d = '0;
    end else if (ph_valid_q && ph_ready && !abort) begin
      sum_d = sum_q + SUM_W'(ph_cycles_q);
    end
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (req_valid) state_d = next_phase(S_IDLE, en_r);
        S_FIN:   state_d = S_IDLE;
        default: if (ph_ready) state_d = next_phase(state_q, en_r);
      endcase
    end
  end

  // Descriptor for the state being entered; constant while the state holds.
  always_comb begin
    ph_valid_d = 1'b0;
    ph_type_d  = PH_CMD;
    ph_lanes_d = LANES_SINGLE;
    ph_dtr_d   = 1'b0;
    ph_nbits_d = '0;
    ph_data_d  = '0;
    is_dummy   = 1'b0;
    case (state_d)
      S_CMD: begin
        ph_valid_d = 1'b1;
        ph_lanes_d = r_lanes_cmd;
        ph_nbits_d = NBITS_W'(8);
        ph_data_d  = PD_W'(r_command) << (PD_W - 8);
      end
      S_ADDR: begin
        ph_valid_d = 1'b1;
        ph_type_d  = PH_ADDR;
        ph_lanes_d = r_lanes_addr;
        ph_dtr_d   = r_dtr;
        if (r_four) begin
          ph_nbits_d = NBITS_W'(32);
          ph_data_d  = PD_W'(addr_ext[31:0]) << ADDR32_SH;
        end else begin
          ph_nbits_d = NBITS_W'(24);
          ph_data_d  = PD_W'(addr_ext[23:0]) << (PD_W - 24);
        end
      end
      S_ALT: begin
        ph_valid_d = 1'b1;
        ph_type_d  = PH_ALT;
        ph_lanes_d = r_lanes_alt;
        ph_dtr_d   = r_dtr;
        ph_nbits_d = NBITS_W'(8);
        ph_data_d  = PD_W'(r_alt) << (PD_W - 8);
      end
      S_DUMMY: begin
        ph_valid_d = 1'b1;
        ph_type_d  = PH_DUMMY;
        is_dummy   = 1'b1;
      end
      S_TX: begin
        ph_valid_d = 1'b1;
        ph_type_d  = PH_TX;
        ph_lanes_d = r_lanes_data;
        ph_dtr_d   = r_dtr;
        ph_nbits_d = tx_nbits;
        ph_data_d  = PD_W'(r_datain) << (PD_W - DATA_W);
      end
      S_RX: begin
        ph_valid_d = 1'b1;
        ph_type_d  = PH_RX;
        ph_lanes_d = r_lanes_data;
        ph_dtr_d   = r_dtr;
        ph_nbits_d = r_nrx;
      end
      default: ;
    endcase
    if (is_dummy) begin
      ph_cycles_d = NBITS_W'(r_dummy);
    end else begin
      ph_cycles_d = NBITS_W'(ceil_div_lanes(CNT_W'(ph_nbits_d), ph_lanes_d, ph_dtr_d));
    end
    ph_last_d = ph_valid_d && (next_phase(state_d, en_r) == S_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      ph_valid_q  <= 1'b0;
      ph_type_q   <= '0;
      ph_lanes_q  <= '0;
      ph_dtr_q    <= 1'b0;
      ph_nbits_q  <= '0;
      ph_cycles_q <= '0;
      ph_data_q   <= '0;
      ph_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      ph_valid_q  <= ph_valid_d;
      ph_type_q   <= ph_type_d;
      ph_lanes_q  <= ph_lanes_d;
      ph_dtr_q    <= ph_dtr_d;
      ph_nbits_q  <= ph_nbits_d;
      ph_cycles_q <= ph_cycles_d;
      ph_data_q   <= ph_data_d;
      ph_last_q   <= ph_last_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  assign req_ready   = (state_q == S_IDLE);
  assign done        = (state_q == S_FIN);
  assign total_edges = {sum_q, 1'b0};
  assign ph_valid    = ph_valid_q;
  assign ph_type     = ph_type_q;
  assign ph_lanes    = ph_lanes_q;
  assign ph_dtr      = ph_dtr_q;
  assign ph_nbits    = ph_nbits_q;
  assign ph_cycles   = ph_cycles_q;
  assign ph_data     = ph_data_q;
  assign ph_last     = ph_last_q;

endmodule
